// File: rtl/axi_mirror_sched.sv
// Mirrors one AXI manager onto a primary/secondary subordinate pair: forks AW/W/AR, joins B/R.
// Optional response comparison is enabled with `define AXI_MIRROR_SCHED_RESPCHK_EN.

package axi_mirror_sched_pkg;
   localparam int unsigned IdWidth   = 4;
   localparam int unsigned AddrWidth = 32;
   localparam int unsigned DataWidth = 32;
   localparam int unsigned StrbWidth = DataWidth / 8;

   typedef struct packed {
      logic [IdWidth-1:0]   aw_id;
      logic [AddrWidth-1:0] aw_addr;
      logic [7:0]           aw_len;
      logic [2:0]           aw_size;
      logic [1:0]           aw_burst;
      logic                 aw_valid;
      logic [DataWidth-1:0] w_data;
      logic [StrbWidth-1:0] w_strb;
      logic                 w_last;
      logic                 w_valid;
      logic                 b_ready;
      logic [IdWidth-1:0]   ar_id;
      logic [AddrWidth-1:0] ar_addr;
      logic [7:0]           ar_len;
      logic [2:0]           ar_size;
      logic [1:0]           ar_burst;
      logic                 ar_valid;
      logic                 r_ready;
   } axi_req_t;

   typedef struct packed {
      logic                 aw_ready;
      logic                 w_ready;
      logic [IdWidth-1:0]   b_id;
      logic [1:0]           b_resp;
      logic                 b_valid;
      logic                 ar_ready;
      logic [IdWidth-1:0]   r_id;
      logic [DataWidth-1:0] r_data;
      logic [1:0]           r_resp;
      logic                 r_last;
      logic                 r_valid;
   } axi_rsp_t;
endpackage

// One-channel fork: a beat is accepted upstream once both sides have taken it.
module axi_mirror_fork (
   input  logic clk_i,
   input  logic rst_i,
   input  logic valid_i,
   input  logic gate_i,
   input  logic p_ready_i,
   input  logic s_ready_i,
   output logic ready_o,
   output logic p_valid_o,
   output logic s_valid_o,
   output logic busy_o
);
   logic done_p_q, done_s_q, held_q, open_c;

   // held_q keeps the gate open for a presented-but-unaccepted beat, so valids stay stable.
   always_comb begin
      open_c    = ~rst_i & (gate_i | done_p_q | done_s_q | held_q);
      p_valid_o = valid_i & ~done_p_q & open_c;
      s_valid_o = valid_i & ~done_s_q & open_c;
      ready_o   = open_c & (p_ready_i | done_p_q) & (s_ready_i | done_s_q);
      busy_o    = done_p_q | done_s_q;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         done_p_q <= 1'b0;
         done_s_q <= 1'b0;
         held_q   <= 1'b0;
      end else if (valid_i & ready_o) begin
         done_p_q <= 1'b0;
         done_s_q <= 1'b0;
         held_q   <= 1'b0;
      end else begin
         done_p_q <= done_p_q | (p_valid_o & p_ready_i);
         done_s_q <= done_s_q | (s_valid_o & s_ready_i);
         held_q   <= valid_i & open_c;
      end
   end
endmodule

module axi_mirror_sched #(
   parameter int unsigned MaxTxns = 8,
   parameter type axi_req_t = axi_mirror_sched_pkg::axi_req_t,
   parameter type axi_rsp_t = axi_mirror_sched_pkg::axi_rsp_t,
   localparam int unsigned CntWidth = $clog2(MaxTxns + 1)
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  axi_req_t            slv_req_i,
   output axi_rsp_t            slv_rsp_o,
   output axi_req_t            p_req_o,
   input  axi_rsp_t            p_rsp_i,
   output axi_req_t            s_req_o,
   input  axi_rsp_t            s_rsp_i,
   input  logic                flush_i,
   output logic                idle_o,
   output logic [CntWidth-1:0] w_out_o,
   output logic [CntWidth-1:0] r_out_o
`ifdef AXI_MIRROR_SCHED_RESPCHK_EN
   ,
   output logic                resp_mismatch_o,
   output logic [15:0]         mismatch_cnt_o
`endif
);
   logic [CntWidth-1:0] w_out_q, r_out_q, sb_cnt_q, sr_cnt_q;
   logic aw_gate_c, ar_gate_c;
   logic aw_ready_c, w_ready_c, ar_ready_c;
   logic p_aw_valid_c, s_aw_valid_c, p_w_valid_c, s_w_valid_c, p_ar_valid_c, s_ar_valid_c;
   logic aw_busy_c, w_busy_c, ar_busy_c;
   logic aw_hs_c, ar_hs_c;
   logic s_b_acc_c, s_r_acc_c, b_ok_c, r_ok_c, b_hs_c, r_last_hs_c;

   assign aw_gate_c = ~flush_i & (w_out_q < CntWidth'(MaxTxns));
   assign ar_gate_c = ~flush_i & (r_out_q < CntWidth'(MaxTxns));

   axi_mirror_fork u_aw_fork (
      .clk_i, .rst_i,
      .valid_i   (slv_req_i.aw_valid),
      .gate_i    (aw_gate_c),
      .p_ready_i (p_rsp_i.aw_ready),
      .s_ready_i (s_rsp_i.aw_ready),
      .ready_o   (aw_ready_c),
      .p_valid_o (p_aw_valid_c),
      .s_valid_o (s_aw_valid_c),
      .busy_o    (aw_busy_c)
   );

   axi_mirror_fork u_w_fork (
      .clk_i, .rst_i,
      .valid_i   (slv_req_i.w_valid),
      .gate_i    (1'b1),
      .p_ready_i (p_rsp_i.w_ready),
      .s_ready_i (s_rsp_i.w_ready),
      .ready_o   (w_ready_c),
      .p_valid_o (p_w_valid_c),
      .s_valid_o (s_w_valid_c),
      .busy_o    (w_busy_c)
   );

   axi_mirror_fork u_ar_fork (
      .clk_i, .rst_i,
      .valid_i   (slv_req_i.ar_valid),
      .gate_i    (ar_gate_c),
      .p_ready_i (p_rsp_i.ar_ready),
      .s_ready_i (s_rsp_i.ar_ready),
      .ready_o   (ar_ready_c),
      .p_valid_o (p_ar_valid_c),
      .s_valid_o (s_ar_valid_c),
      .busy_o    (ar_busy_c)
   );

   // S completions are only counted while a matching burst is outstanding.
   always_comb begin
      aw_hs_c     = slv_req_i.aw_valid & aw_ready_c;
      ar_hs_c     = slv_req_i.ar_valid & ar_ready_c;
      s_b_acc_c   = s_rsp_i.b_valid & (sb_cnt_q < w_out_q);
      s_r_acc_c   = s_rsp_i.r_valid & s_rsp_i.r_last & (sr_cnt_q < r_out_q);
      b_ok_c      = ~rst_i & ((sb_cnt_q != '0) | s_b_acc_c);
      r_ok_c      = ~rst_i & (~p_rsp_i.r_last | (sr_cnt_q != '0) | s_r_acc_c);
      b_hs_c      = p_rsp_i.b_valid & slv_req_i.b_ready & b_ok_c;
      r_last_hs_c = p_rsp_i.r_valid & p_rsp_i.r_last & slv_req_i.r_ready & r_ok_c;
   end

   always_comb begin
      slv_rsp_o          = p_rsp_i;
      slv_rsp_o.aw_ready = aw_ready_c;
      slv_rsp_o.w_ready  = w_ready_c;
      slv_rsp_o.ar_ready = ar_ready_c;
      slv_rsp_o.b_valid  = p_rsp_i.b_valid & b_ok_c;
      slv_rsp_o.r_valid  = p_rsp_i.r_valid & r_ok_c;

      p_req_o            = slv_req_i;
      p_req_o.aw_valid   = p_aw_valid_c;
      p_req_o.w_valid    = p_w_valid_c;
      p_req_o.ar_valid   = p_ar_valid_c;
      p_req_o.b_ready    = slv_req_i.b_ready & b_ok_c;
      p_req_o.r_ready    = slv_req_i.r_ready & r_ok_c;

      s_req_o            = slv_req_i;
      s_req_o.aw_valid   = s_aw_valid_c;
      s_req_o.w_valid    = s_w_valid_c;
      s_req_o.ar_valid   = s_ar_valid_c;
      s_req_o.b_ready    = 1'b1;
      s_req_o.r_ready    = 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         w_out_q  <= '0;
         r_out_q  <= '0;
         sb_cnt_q <= '0;
         sr_cnt_q <= '0;
      end else begin
         w_out_q  <= w_out_q + CntWidth'(aw_hs_c) - CntWidth'(b_hs_c);
         r_out_q  <= r_out_q + CntWidth'(ar_hs_c) - CntWidth'(r_last_hs_c);
         sb_cnt_q <= sb_cnt_q + CntWidth'(s_b_acc_c) - CntWidth'(b_hs_c);
         sr_cnt_q <= sr_cnt_q + CntWidth'(s_r_acc_c) - CntWidth'(r_last_hs_c);
      end
   end

   assign w_out_o = w_out_q;
   assign r_out_o = r_out_q;
   assign idle_o  = (w_out_q == '0) & (r_out_q == '0) & (sb_cnt_q == '0) & (sr_cnt_q == '0)
                  & ~aw_busy_c & ~w_busy_c & ~ar_busy_c;

   // A secondary completion with no burst left to match means the mirrors diverged.
   a_s_b_orphan : assert property (@(posedge clk_i) disable iff (rst_i)
      s_rsp_i.b_valid |-> (sb_cnt_q < w_out_q));
   a_s_r_orphan : assert property (@(posedge clk_i) disable iff (rst_i)
      (s_rsp_i.r_valid & s_rsp_i.r_last) |-> (sr_cnt_q < r_out_q));

`ifdef AXI_MIRROR_SCHED_RESPCHK_EN
   localparam int unsigned PtrWidth = (MaxTxns > 1) ? $clog2(MaxTxns) : 1;

   logic [1:0]          b_fifo_q [MaxTxns];
   logic [1:0]          r_fifo_q [MaxTxns];
   logic [PtrWidth-1:0] b_wr_q, b_rd_q, r_wr_q, r_rd_q;
   logic [1:0]          b_head_c, r_head_c;
   logic                b_push_c, b_pop_c, r_push_c, r_pop_c, b_mis_c, r_mis_c;
   logic [16:0]         cnt_sum_c;

   function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] ptr);
      return (ptr == PtrWidth'(MaxTxns - 1)) ? '0 : ptr + PtrWidth'(1);
   endfunction

   // An empty FIFO bypasses the S response arriving in the same cycle as the P handshake.
   always_comb begin
      b_head_c  = (sb_cnt_q == '0) ? s_rsp_i.b_resp : b_fifo_q[b_rd_q];
      r_head_c  = (sr_cnt_q == '0) ? s_rsp_i.r_resp : r_fifo_q[r_rd_q];
      b_pop_c   = b_hs_c & (sb_cnt_q != '0);
      r_pop_c   = r_last_hs_c & (sr_cnt_q != '0);
      b_push_c  = s_b_acc_c & ~(b_hs_c & (sb_cnt_q == '0));
      r_push_c  = s_r_acc_c & ~(r_last_hs_c & (sr_cnt_q == '0));
      b_mis_c   = b_hs_c & (p_rsp_i.b_resp != b_head_c);
      r_mis_c   = r_last_hs_c & (p_rsp_i.r_resp != r_head_c);
      cnt_sum_c = 17'(mismatch_cnt_o) + 17'(b_mis_c) + 17'(r_mis_c);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         b_wr_q          <= '0;
         b_rd_q          <= '0;
         r_wr_q          <= '0;
         r_rd_q          <= '0;
         resp_mismatch_o <= 1'b0;
         mismatch_cnt_o  <= '0;
      end else begin
         if (b_push_c) begin
            b_fifo_q[b_wr_q] <= s_rsp_i.b_resp;
            b_wr_q           <= ptr_inc(b_wr_q);
         end
         if (b_pop_c) b_rd_q <= ptr_inc(b_rd_q);
         if (r_push_c) begin
            r_fifo_q[r_wr_q] <= s_rsp_i.r_resp;
            r_wr_q           <= ptr_inc(r_wr_q);
         end
         if (r_pop_c) r_rd_q <= ptr_inc(r_rd_q);
         resp_mismatch_o <= b_mis_c | r_mis_c;
         mismatch_cnt_o  <= cnt_sum_c[16] ? 16'hFFFF : cnt_sum_c[15:0];
      end
   end

   logic unused_s_rsp;
   assign unused_s_rsp = ^s_rsp_i;
`else
   // Secondary payload is sunk without comparison in this build.
   logic unused_s_rsp;
   assign unused_s_rsp = ^s_rsp_i;
`endif
endmodule
